// File: rtl/cfi_pkg.sv
// Shared CFI types: log entry format, mailbox scheduler state
// encoding and default verdict timeout.
package cfi_pkg;

    typedef struct packed {
        logic [31:0] src_pc;
        logic [31:0] dst_pc;
        logic [1:0]  kind;
    } cfi_log_t;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        GRANT        = 2'd1,
        WAIT_VERDICT = 2'd2
    } cfi_sched_state_e;

    localparam int unsigned CFI_MBOX_TIMEOUT = 1024;

endpackage

// File: rtl/cfi_rr_picker.sv
// Round-robin picker: first set request bit at or after ptr,
// wrapping modulo N.
module cfi_rr_picker #(
    parameter int N = 2,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         valid,
    output logic [W-1:0] idx
);

    int j;

    // Scan from the pointer and keep the first hit.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr) + i) % N;
            if (!valid && req[j]) begin
                valid = 1'b1;
                idx   = W'(j);
            end
        end
    end

endmodule

// File: rtl/cfi_mbox_sched.sv
// Round-robin scheduler from per-source CFI log queues to the single
// mailbox backend, with verdict wait, timeout and fault reporting.
module cfi_mbox_sched
    import cfi_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = CFI_MBOX_TIMEOUT,
    parameter int ID_W           = $clog2(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  cfi_log_t           req_log_i [NUM_REQ],
    input  logic [NUM_REQ-1:0] req_empty_i,
    output logic [NUM_REQ-1:0] req_pop_o,
    output cfi_log_t           be_log_o,
    output logic               be_empty_o,
    input  logic               be_pop_i,
    input  logic               mbox_done_i,
    input  logic               mbox_violation_i,
    output logic               fault_valid_o,
    output logic [ID_W-1:0]    fault_id_o,
    output logic               fault_timeout_o,
    output logic               busy_o
);

    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TIMER_W-1:0] TIMER_MAX = '1;

    cfi_sched_state_e   state_q, state_d;
    logic [ID_W-1:0]    grant_q, grant_d;
    logic [ID_W-1:0]    rr_q, rr_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               fv_q, fv_d;
    logic [ID_W-1:0]    fid_q, fid_d;
    logic               fto_q, fto_d;

    logic               pick_valid;
    logic [ID_W-1:0]    pick_idx;

    cfi_rr_picker #(
        .N (NUM_REQ),
        .W (ID_W)
    ) u_picker (
        .req   (~req_empty_i),
        .ptr   (rr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // State, pointer, timer and fault registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            timer_q <= '0;
            fv_q    <= 1'b0;
            fid_q   <= '0;
            fto_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            timer_q <= timer_d;
            fv_q    <= fv_d;
            fid_q   <= fid_d;
            fto_q   <= fto_d;
        end
    end

    // Next-state logic and backend-facing outputs.
    // The timer is 0 on the entry cycle; expiry is decided once it has
    // counted TIMEOUT_CYCLES further cycles, a verdict in that same
    // cycle taking priority.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_d       = rr_q;
        timer_d    = timer_q;
        fv_d       = 1'b0;
        fid_d      = fid_q;
        fto_d      = fto_q;
        be_empty_o = 1'b1;
        req_pop_o  = '0;
        be_log_o   = req_log_i[grant_q];

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                be_empty_o         = req_empty_i[grant_q] | rst_i;
                req_pop_o[grant_q] = be_pop_i & ~rst_i;
                if (be_pop_i) begin
                    state_d = WAIT_VERDICT;
                    timer_d = '0;
                    rr_d    = (grant_q == ID_W'(NUM_REQ - 1))
                            ? '0 : grant_q + ID_W'(1);
                end
            end
            WAIT_VERDICT: begin
                if (timer_q != TIMER_MAX) begin
                    timer_d = timer_q + TIMER_W'(1);
                end
                if (mbox_done_i) begin
                    state_d = IDLE;
                    if (mbox_violation_i) begin
                        fv_d  = 1'b1;
                        fid_d = grant_q;
                        fto_d = 1'b0;
                    end
                end else if (timer_q == TIMER_W'(TIMEOUT_CYCLES)) begin
                    state_d = IDLE;
                    fv_d    = 1'b1;
                    fid_d   = grant_q;
                    fto_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign fault_valid_o   = fv_q;
    assign fault_id_o      = fid_q;
    assign fault_timeout_o = fto_q;
    assign busy_o          = (state_q != IDLE) && !rst_i;

endmodule

// File: tb/tb_cfi_mbox_sched.sv
// Directed bench for cfi_mbox_sched: NUM_REQ=2, TIMEOUT_CYCLES=16,
// hand-computed expectations checked with immediate assertions.
module tb_cfi_mbox_sched;
    import cfi_pkg::*;

    logic       clk;
    logic       rst;
    cfi_log_t   log_in [2];
    logic [1:0] empty;
    logic [1:0] pop;
    cfi_log_t   be_log;
    logic       be_empty;
    logic       be_pop;
    logic       done;
    logic       viol;
    logic       fv;
    logic [0:0] fid;
    logic       fto;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    cfi_mbox_sched #(
        .NUM_REQ        (2),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .req_log_i        (log_in),
        .req_empty_i      (empty),
        .req_pop_o        (pop),
        .be_log_o         (be_log),
        .be_empty_o       (be_empty),
        .be_pop_i         (be_pop),
        .mbox_done_i      (done),
        .mbox_violation_i (viol),
        .fault_valid_o    (fv),
        .fault_id_o       (fid),
        .fault_timeout_o  (fto),
        .busy_o           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] exp_pop;
        int         exp_id;

        rst    = 1'b1;
        empty  = 2'b11;
        be_pop = 1'b0;
        done   = 1'b0;
        viol   = 1'b0;
        log_in[0] = '{src_pc: 32'h1000_0010, dst_pc: 32'h2000_0020, kind: 2'd1};
        log_in[1] = '{src_pc: 32'h3000_0030, dst_pc: 32'h4000_0040, kind: 2'd2};

        // reset values
        nxt();
        nxt();
        chk("rst_be_empty", be_empty, 1);
        chk("rst_pop", pop, 0);
        chk("rst_fv", fv, 0);
        chk("rst_fid", fid, 0);
        chk("rst_fto", fto, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        nxt();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_be_empty", be_empty, 1);

        // single source: grant 0, pop, clean verdict
        empty = 2'b10;
        #1;
        chk("s1_idle_busy", busy, 0);
        nxt();
        chk("s1_grant_be_empty", be_empty, 0);
        chk("s1_grant_busy", busy, 1);
        chk("s1_grant_log", be_log, log_in[0]);
        chk("s1_grant_nopop", pop, 2'b00);
        repeat (8) nxt();
        be_pop = 1'b1;
        #1;
        chk("s1_pop", pop, 2'b01);
        nxt();
        be_pop = 1'b0;
        empty  = 2'b11;
        #1;
        chk("s1_wait_be_empty", be_empty, 1);
        chk("s1_wait_busy", busy, 1);
        chk("s1_wait_nopop", pop, 2'b00);
        repeat (8) nxt();
        done = 1'b1;
        #1;
        nxt();
        done = 1'b0;
        #1;
        chk("s1_done_busy", busy, 0);
        chk("s1_done_nofault", fv, 0);

        // spurious pop in IDLE
        be_pop = 1'b1;
        #1;
        chk("sp_idle_pop", pop, 2'b00);
        nxt();
        be_pop = 1'b0;
        #1;
        chk("sp_idle_busy", busy, 0);

        // violation from source 1; spurious done while in GRANT
        empty = 2'b01;
        #1;
        nxt();
        chk("v_grant_log", be_log, log_in[1]);
        done = 1'b1;
        viol = 1'b1;
        #1;
        nxt();
        done = 1'b0;
        viol = 1'b0;
        #1;
        chk("sp_grant_nofault", fv, 0);
        chk("sp_grant_busy", busy, 1);
        chk("v_grant_be_empty", be_empty, 0);
        be_pop = 1'b1;
        #1;
        chk("v_pop", pop, 2'b10);
        nxt();
        be_pop = 1'b0;
        empty  = 2'b11;
        done   = 1'b1;
        viol   = 1'b1;
        #1;
        nxt();
        done = 1'b0;
        viol = 1'b0;
        #1;
        chk("v_fv", fv, 1);
        chk("v_fid", fid, 1);
        chk("v_fto", fto, 0);
        chk("v_busy", busy, 0);
        nxt();
        chk("v_fv_once", fv, 0);
        chk("v_fid_hold", fid, 1);

        // timeout on source 0: pulse 17 cycles after entry
        empty = 2'b10;
        #1;
        nxt();
        chk("t_grant_log", be_log, log_in[0]);
        be_pop = 1'b1;
        #1;
        nxt();
        be_pop = 1'b0;
        empty  = 2'b11;
        #1;
        for (int k = 1; k <= 16; k++) begin
            nxt();
            chk($sformatf("t_quiet_%0d", k), {fv, busy}, 2'b01);
        end
        nxt();
        chk("t_fv", fv, 1);
        chk("t_fto", fto, 1);
        chk("t_fid", fid, 0);
        chk("t_busy", busy, 0);
        nxt();
        chk("t_fv_once", fv, 0);

        // verdict on the expiry cycle wins over the timeout
        empty = 2'b01;
        #1;
        nxt();
        chk("vw_grant_log", be_log, log_in[1]);
        be_pop = 1'b1;
        #1;
        nxt();
        be_pop = 1'b0;
        empty  = 2'b11;
        #1;
        repeat (16) nxt();
        done = 1'b1;
        viol = 1'b0;
        #1;
        nxt();
        done = 1'b0;
        #1;
        chk("vw_nofault", fv, 0);
        chk("vw_busy", busy, 0);
        chk("vw_fto_hold", fto, 1);
        chk("vw_fid_hold", fid, 0);
        nxt();
        chk("vw_nofault_late", fv, 0);

        // reset while waiting for a verdict, with a verdict pending
        empty = 2'b10;
        #1;
        nxt();
        be_pop = 1'b1;
        #1;
        nxt();
        be_pop = 1'b0;
        empty  = 2'b11;
        #1;
        nxt();
        rst  = 1'b1;
        done = 1'b1;
        viol = 1'b1;
        #1;
        chk("r_during_pop", pop, 2'b00);
        chk("r_during_be_empty", be_empty, 1);
        chk("r_during_busy", busy, 0);
        nxt();
        rst  = 1'b0;
        done = 1'b0;
        viol = 1'b0;
        #1;
        chk("r_fv", fv, 0);
        chk("r_fid", fid, 0);
        chk("r_fto", fto, 0);
        chk("r_busy", busy, 0);
        chk("r_be_empty", be_empty, 1);

        // round-robin with both sources busy: 0,1,0,1
        empty = 2'b00;
        #1;
        nxt();
        for (int i = 0; i < 4; i++) begin
            exp_id  = i % 2;
            exp_pop = 2'b01 << exp_id;
            chk($sformatf("rr%0d_be_empty", i), be_empty, 0);
            chk($sformatf("rr%0d_log", i), be_log, log_in[exp_id]);
            be_pop = 1'b1;
            #1;
            chk($sformatf("rr%0d_pop", i), pop, exp_pop);
            nxt();
            be_pop = 1'b0;
            done   = 1'b1;
            #1;
            chk($sformatf("rr%0d_wait_busy", i), busy, 1);
            nxt();
            done = 1'b0;
            #1;
            chk($sformatf("rr%0d_idle", i), {fv, busy}, 2'b00);
            nxt();
        end

        empty = 2'b11;
        nxt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
